// File: rtl/serial_addsub_compare.sv
// Digit-serial unsigned add / subtract / magnitude compare.
// Processes DIGIT bits per cycle from the LSB upward; one result every NUM+2
// cycles with out_ready tied high. Ready/valid on both operand and result side.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operation (in_ready once out of reset)
// RUN   | one digit per cycle, counter 0..NUM-1
// DONE  | result registers valid, waiting for out_ready
module serial_addsub_compare #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             busy
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub_compare: illegal WIDTH/DIGIT combination");
  end

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GT  = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             init_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_full;
  logic [2:0]       op_q;
  logic             c_q, nz_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;

  logic             accept, last;
  int               idx;
  logic [DIGIT-1:0] a_dig, b_dig, dig_res;
  logic [DIGIT:0]   sum_w, diff_w;
  logic             is_add, c_nxt, nz_nxt, f_lt, f_gt, f_eq;

  assign accept = in_valid && in_ready;
  assign last   = (state_q == S_RUN) && (cnt_q == CW'(NUM - 1));

  // Digit slice and per-digit add / subtract with carry-in or borrow-in
  assign idx     = int'(cnt_q) * DIGIT;
  assign a_dig   = a_q[idx +: DIGIT];
  assign b_dig   = b_q[idx +: DIGIT];
  assign sum_w   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, c_q};
  assign diff_w  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, c_q};
  assign is_add  = (op_q == OP_ADD);
  assign dig_res = is_add ? sum_w[DIGIT-1:0] : diff_w[DIGIT-1:0];
  assign c_nxt   = is_add ? sum_w[DIGIT] : diff_w[DIGIT];
  assign nz_nxt  = nz_q | (|diff_w[DIGIT-1:0]);

  // Final-cycle flags include the digit being processed on the DONE edge
  assign f_lt = c_nxt;
  assign f_eq = !nz_nxt;
  assign f_gt = !f_lt && !f_eq;

  // Result register with the current digit merged in
  always_comb begin
    res_full = res_q;
    res_full[idx +: DIGIT] = dig_res;
  end

  // Values loaded into the output registers when RUN completes
  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    lt_d    = 1'b0;
    gt_d    = 1'b0;
    eq_d    = 1'b0;
    case (op_q)
      OP_ADD: begin
        out_d   = res_full;
        carry_d = c_nxt;
      end
      OP_SUB, OP_LT, OP_GT, OP_EQ: begin
        carry_d = c_nxt;
        lt_d    = f_lt;
        gt_d    = f_gt;
        eq_d    = f_eq;
        if (op_q == OP_SUB)     out_d    = res_full;
        else if (op_q == OP_LT) out_d[0] = f_lt;
        else if (op_q == OP_GT) out_d[0] = f_gt;
        else                    out_d[0] = f_eq;
      end
      default: ;
    endcase
  end

  // FSM state register; init_q holds off in_ready until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = init_q && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Operand capture and digit-serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      nz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= in1;
      b_q   <= in2;
      op_q  <= op;
      c_q   <= 1'b0;
      nz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      res_q <= res_full;
      c_q   <= c_nxt;
      nz_q  <= nz_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output registers load only on the RUN->DONE edge and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else if (last) begin
      out_q   <= out_d;
      carry_q <= carry_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign lt    = lt_q;
  assign gt    = gt_q;
  assign eq    = eq_q;

endmodule
